// File: rtl/cmd_bus_arbiter.sv
// cmd_bus_arbiter
//
// Purpose: shares one command-bus slave between NUM_MASTERS requesters.
//   Each requester issues a one-clock sel pulse. The arbiter latches the
//   command into that requester's slot, picks pending slots round-robin,
//   issues them to the slave one at a time, and returns ack or timeout
//   (plus read data) to the requester that was granted.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_m_sel            per-requester one-clock request pulse
//   i_m_rd_wr_n        per-requester 1 = read, 0 = write
//   i_m_byte_addr      packed per-requester address, slice k*ADDR_BITS
//   i_m_wdata          packed per-requester write data, slice k*DATA_BITS
//   o_m_ack            one-hot completion pulse to the granted requester
//   o_m_timeout        one-hot timeout pulse to the granted requester
//   o_m_rdata          read data, updated on ack, held otherwise
//   o_m_pending        request latched and not yet completed
//   o_s_sel            one-clock request to the slave
//   o_s_rd_wr_n, o_s_byte_addr, o_s_wdata   slave command fields
//   i_s_ack, i_s_rdata, i_s_timeout         slave response
//   o_grant_idx        current or last granted requester
//
// state | meaning
// IDLE  | no transaction; pick next pending slot round-robin
// ISSUE | o_s_sel high for one cycle, counter cleared
// WAIT  | waiting for slave ack/timeout or backstop count
module cmd_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 32,
  parameter int P_TIMEOUT_CLKS = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_MASTERS-1:0]           i_m_sel,
  input  logic [NUM_MASTERS-1:0]           i_m_rd_wr_n,
  input  logic [NUM_MASTERS*ADDR_BITS-1:0] i_m_byte_addr,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] i_m_wdata,
  output logic [NUM_MASTERS-1:0]           o_m_ack,
  output logic [NUM_MASTERS-1:0]           o_m_timeout,
  output logic [DATA_BITS-1:0]             o_m_rdata,
  output logic [NUM_MASTERS-1:0]           o_m_pending,
  output logic                             o_s_sel,
  output logic                             o_s_rd_wr_n,
  output logic [ADDR_BITS-1:0]             o_s_byte_addr,
  output logic [DATA_BITS-1:0]             o_s_wdata,
  input  logic                             i_s_ack,
  input  logic [DATA_BITS-1:0]             i_s_rdata,
  input  logic                             i_s_timeout,
  output logic [$clog2(NUM_MASTERS)-1:0]   o_grant_idx
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(P_TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_MASTERS-1:0] pending;
  logic                   slot_rd   [NUM_MASTERS];
  logic [ADDR_BITS-1:0]   slot_addr [NUM_MASTERS];
  logic [DATA_BITS-1:0]   slot_wdata[NUM_MASTERS];

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [CNT_W-1:0]       cnt;
  logic                   load;
  logic                   done_ack;
  logic                   done_to;
  logic                   done;
  logic [NUM_MASTERS-1:0] clr_vec;
  logic [SUM_W-1:0]       sum;

  assign o_m_pending = pending;
  assign o_grant_idx = grant;
  assign done        = done_ack | done_to;

  // Round-robin pick: walk offsets from high to low so the smallest
  // offset from rr_ptr that is pending wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_MASTERS)) begin
        sum = sum - SUM_W'(NUM_MASTERS);
      end
      if (pending[sum[IDX_W-1:0]]) begin
        pick_idx = sum[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      clr_vec[k] = done && (grant == IDX_W'(k));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack beats timeout when both arrive together.
  always_comb begin
    state_nxt = state;
    o_s_sel   = 1'b0;
    load      = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_s_sel = 1'b1;
        if (i_s_ack) begin
          done_ack = 1'b1;
        end else if (i_s_timeout) begin
          done_to = 1'b1;
        end
        state_nxt = (i_s_ack || i_s_timeout) ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_s_ack) begin
          done_ack = 1'b1;
        end else if (i_s_timeout || (cnt == CNT_W'(P_TIMEOUT_CLKS - 1))) begin
          done_to = 1'b1;
        end
        if (i_s_ack || i_s_timeout || (cnt == CNT_W'(P_TIMEOUT_CLKS - 1))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter only runs in WAIT and leaves WAIT at P_TIMEOUT_CLKS-1, so it
  // never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (state == WAIT && !done) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Request capture. A new sel in the completion cycle of the same slot is
  // accepted (set wins over clear).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        slot_rd[k]    <= 1'b0;
        slot_addr[k]  <= '0;
        slot_wdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (i_m_sel[k] && (!pending[k] || clr_vec[k])) begin
          pending[k]    <= 1'b1;
          slot_rd[k]    <= i_m_rd_wr_n[k];
          slot_addr[k]  <= i_m_byte_addr[k*ADDR_BITS +: ADDR_BITS];
          slot_wdata[k] <= i_m_wdata[k*DATA_BITS +: DATA_BITS];
        end else if (clr_vec[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  // Slave fields are loaded on grant and held until the next grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant         <= '0;
      rr_ptr        <= '0;
      o_s_rd_wr_n   <= 1'b0;
      o_s_byte_addr <= '0;
      o_s_wdata     <= '0;
      o_m_ack       <= '0;
      o_m_timeout   <= '0;
      o_m_rdata     <= '0;
    end else begin
      if (load) begin
        grant         <= pick_idx;
        o_s_rd_wr_n   <= slot_rd[pick_idx];
        o_s_byte_addr <= slot_addr[pick_idx];
        o_s_wdata     <= slot_wdata[pick_idx];
      end
      o_m_ack     <= done_ack ? clr_vec : '0;
      o_m_timeout <= done_to  ? clr_vec : '0;
      if (done_ack) begin
        o_m_rdata <= i_s_rdata;
      end
      if (done) begin
        rr_ptr <= (grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

endmodule
